// File: rtl/jt12_lfo_gen.sv
// jt12 LFO generator: prescales the sample strobe by the
// register 0x22 rate and produces the LFO phase, PM index and AM level.
module jt12_lfo_gen #(
    parameter int NUM_RATES = 8
) (
    input  logic                         rst_n,
    input  logic                         clk,
    input  logic                         clk_en,
    input  logic                         zero,
    input  logic                         lfo_en,
    input  logic [$clog2(NUM_RATES)-1:0] lfo_freq,
    output logic [6:0]                   lfo_mod,
    output logic [4:0]                   pm_mod,
    output logic [5:0]                   am_mod
);

    logic [6:0] r_cnt;
    logic [6:0] r_mod;
    logic [6:0] w_limit;
    logic       w_step;

    // Rate table: strobes per phase step, minus one.
    always_comb begin
        w_limit = 7'd107;
        unique case (lfo_freq)
            3'd0:    w_limit = 7'd107;
            3'd1:    w_limit = 7'd76;
            3'd2:    w_limit = 7'd70;
            3'd3:    w_limit = 7'd66;
            3'd4:    w_limit = 7'd61;
            3'd5:    w_limit = 7'd43;
            3'd6:    w_limit = 7'd7;
            3'd7:    w_limit = 7'd4;
            default: w_limit = 7'd107;
        endcase
    end

    // >= so a rate change below the current count steps at once.
    assign w_step = r_cnt >= w_limit;

    // Prescaler and phase counter; disable clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 7'd0;
            r_mod <= 7'd0;
        end else if (clk_en) begin
            if (!lfo_en) begin
                r_cnt <= 7'd0;
                r_mod <= 7'd0;
            end else if (zero) begin
                if (w_step) begin
                    r_cnt <= 7'd0;
                    r_mod <= r_mod + 7'd1;
                end else begin
                    r_cnt <= r_cnt + 7'd1;
                end
            end
        end
    end

    assign lfo_mod = r_mod;
    assign pm_mod  = r_mod[6:2];
    assign am_mod  = r_mod[6] ? r_mod[5:0] : ~r_mod[5:0];

endmodule
